// File: rtl/dec_2to4.sv
`default_nettype none
// ============================================================================
// Module   : dec_2to4
// Purpose  : Registered 2-to-4 decoder built twice -- once from AND/NOT gate
//            terms, once from a case selection -- with the two results
//            compared every cycle. A sticky error flag records any enabled
//            cycle on which the two decode paths disagreed.
// Ports    : clk       in   1  rising-edge clock
//            rst_n     in   1  asynchronous active-low reset
//            en        in   1  decode enable, sampled on clk
//            in        in   2  select code
//            err_clr   in   1  clears the sticky error flag
//            out_logic out  4  registered gate-level decode
//            out_cond  out  4  registered case-based decode
//            out_valid out  1  outputs hold a decode of an enabled sample
//            match     out  1  registered equality of the two paths
//            err       out  1  sticky path-mismatch flag
// Params   : ACTIVE_LOW  0 = one-hot outputs, 1 = one-cold outputs
// Revision : 1.0  initial release
// ============================================================================
module dec_2to4 #(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] in,
  input  logic       err_clr,
  output logic [3:0] out_logic,
  output logic [3:0] out_cond,
  output logic       out_valid,
  output logic       match,
  output logic       err
);

  // Value every output line takes when nothing is selected.
  localparam logic [3:0] C_INACTIVE = ACTIVE_LOW ? 4'b1111 : 4'b0000;

  logic [3:0] w_logic_raw;   // active-high gate-level decode
  logic [3:0] w_cond_raw;    // active-high case-based decode
  logic [3:0] w_logic_dec;   // polarity-adjusted gate-level decode
  logic [3:0] w_cond_dec;    // polarity-adjusted case-based decode
  logic [3:0] w_logic_sel;   // value loaded into out_logic this edge
  logic [3:0] w_cond_sel;    // value loaded into out_cond this edge
  logic       w_mismatch;    // paths disagree on an enabled cycle

  // Gate-level path: pure AND/NOT minterms of the select code.
  assign w_logic_raw[0] = ~in[1] & ~in[0];
  assign w_logic_raw[1] = ~in[1] &  in[0];
  assign w_logic_raw[2] =  in[1] & ~in[0];
  assign w_logic_raw[3] =  in[1] &  in[0];

  // Conditional path: the default branch catches X/Z on the select code in
  // simulation and yields all-inactive rather than propagating unknowns.
  always_comb begin
    w_cond_raw = 4'b0000;
    case (in)
      2'b00:   w_cond_raw = 4'b0001;
      2'b01:   w_cond_raw = 4'b0010;
      2'b10:   w_cond_raw = 4'b0100;
      2'b11:   w_cond_raw = 4'b1000;
      default: w_cond_raw = 4'b0000;
    endcase
  end

  // Polarity is applied after decoding so the all-inactive default of the
  // case path also inverts to all-ones in one-cold mode.
  assign w_logic_dec = ACTIVE_LOW ? ~w_logic_raw : w_logic_raw;
  assign w_cond_dec  = ACTIVE_LOW ? ~w_cond_raw  : w_cond_raw;

  // Disabled cycles load all-inactive on both paths, so they always match.
  assign w_logic_sel = en ? w_logic_dec : C_INACTIVE;
  assign w_cond_sel  = en ? w_cond_dec  : C_INACTIVE;
  assign w_mismatch  = en & (w_logic_dec != w_cond_dec);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_logic <= C_INACTIVE;
      out_cond  <= C_INACTIVE;
      out_valid <= 1'b0;
      match     <= 1'b1;
      err       <= 1'b0;
    end else begin
      out_logic <= w_logic_sel;
      out_cond  <= w_cond_sel;
      out_valid <= en;
      match     <= (w_logic_sel == w_cond_sel);
      // A fresh mismatch wins over a simultaneous clear request.
      if (w_mismatch) begin
        err <= 1'b1;
      end else if (err_clr) begin
        err <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dec_2to4.sv
`default_nettype none
// ============================================================================
// Module   : tb_dec_2to4
// Purpose  : Self-checking bench for dec_2to4. Drives one active-high and one
//            active-low instance with the same stimulus and compares each
//            against a behavioural model (shift-based decode, sticky error).
// Revision : 1.0  initial release
// ============================================================================
module tb_dec_2to4;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [1:0] in;
  logic       err_clr;

  logic [3:0] hi_logic, hi_cond, lo_logic, lo_cond;
  logic       hi_valid, hi_match, hi_err;
  logic       lo_valid, lo_match, lo_err;

  int total;
  int passed;

  // Model state
  bit       err_hi_m;
  bit       err_lo_m;

  dec_2to4 #(.ACTIVE_LOW(1'b0)) dut_hi (
    .clk(clk), .rst_n(rst_n), .en(en), .in(in), .err_clr(err_clr),
    .out_logic(hi_logic), .out_cond(hi_cond), .out_valid(hi_valid),
    .match(hi_match), .err(hi_err)
  );

  dec_2to4 #(.ACTIVE_LOW(1'b1)) dut_lo (
    .clk(clk), .rst_n(rst_n), .en(en), .in(in), .err_clr(err_clr),
    .out_logic(lo_logic), .out_cond(lo_cond), .out_valid(lo_valid),
    .match(lo_match), .err(lo_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Expected decode: enabled -> 1 shifted left by the code, else nothing;
  // active-low mode is the bitwise inverse.
  function automatic logic [3:0] model_dec(bit al, bit e, logic [1:0] code);
    logic [3:0] v;
    v = e ? 4'(1 << code) : 4'd0;
    return al ? ~v : v;
  endfunction

  task automatic chk(string tag, logic [3:0] obs, logic [3:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic chk_onehot(string tag, logic [3:0] obs, bit al);
    logic [3:0] act;
    act = al ? ~obs : obs;
    total++;
    assert ($countones(act) == 1) passed++;
    else $error("FAIL %s observed=%b expected=exactly one active bit", tag, obs);
  endtask

  // Check both instances against the model. fault=1 means the hi instance's
  // case path was forced to 0000 during the step.
  task automatic check_all(string tag, bit e, logic [1:0] code, bit fault);
    bit hi_mis;
    hi_mis = fault && e && (model_dec(1'b0, 1'b1, code) != 4'b0000);
    chk({tag, " hi.out_logic"}, hi_logic, model_dec(1'b0, e, code));
    chk({tag, " hi.out_cond"},  hi_cond,  fault && e ? 4'b0000 : model_dec(1'b0, e, code));
    chk({tag, " hi.out_valid"}, {3'b0, hi_valid}, {3'b0, e});
    chk({tag, " hi.match"},     {3'b0, hi_match}, {3'b0, !hi_mis});
    chk({tag, " hi.err"},       {3'b0, hi_err},   {3'b0, err_hi_m});
    chk({tag, " lo.out_logic"}, lo_logic, model_dec(1'b1, e, code));
    chk({tag, " lo.out_cond"},  lo_cond,  model_dec(1'b1, e, code));
    chk({tag, " lo.out_valid"}, {3'b0, lo_valid}, {3'b0, e});
    chk({tag, " lo.match"},     {3'b0, lo_match}, 4'b0001);
    chk({tag, " lo.err"},       {3'b0, lo_err},   {3'b0, err_lo_m});
    if (e) begin
      chk_onehot({tag, " lo.onecold_logic"}, lo_logic, 1'b1);
      chk_onehot({tag, " lo.onecold_cond"},  lo_cond,  1'b1);
      if (!fault) begin
        chk_onehot({tag, " hi.onehot_logic"}, hi_logic, 1'b0);
        chk_onehot({tag, " hi.onehot_cond"},  hi_cond,  1'b0);
      end
    end
  endtask

  // One clock: drive inputs, advance the model on the edge, sample at negedge.
  task automatic step(string tag, bit e, logic [1:0] code, bit clr, bit fault);
    bit hi_mis;
    en      = e;
    in      = code;
    err_clr = clr;
    if (fault) force dut_hi.w_cond_dec = 4'b0000;
    hi_mis = fault && e && (model_dec(1'b0, 1'b1, code) != 4'b0000);
    @(posedge clk);
    err_hi_m = hi_mis ? 1'b1 : (clr ? 1'b0 : err_hi_m);
    err_lo_m = clr ? 1'b0 : err_lo_m;
    @(negedge clk);
    if (fault) release dut_hi.w_cond_dec;
    check_all(tag, e, code, fault);
  endtask

  initial begin
    total    = 0;
    passed   = 0;
    err_hi_m = 1'b0;
    err_lo_m = 1'b0;
    en       = 1'b0;
    in       = 2'b00;
    err_clr  = 1'b0;
    rst_n    = 1'b1;

    // Reset values, observed while reset is held and before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    check_all("reset", 1'b0, 2'b00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Sweep of every select code with enable high.
    for (int i = 0; i < 4; i++) step("sweep", 1'b1, 2'(i), 1'b0, 1'b0);

    // Async reset between edges while hi outputs are 1000.
    #2 rst_n = 1'b0;
    #1;
    check_all("midreset", 1'b0, 2'b00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step("after_reset", 1'b1, 2'b00, 1'b0, 1'b0);

    // Disabled cycle.
    step("disable", 1'b0, 2'b10, 1'b0, 1'b0);

    // Active-low directed codes.
    step("al_in1", 1'b1, 2'b01, 1'b0, 1'b0);
    step("al_in3", 1'b1, 2'b11, 1'b0, 1'b0);

    // Sticky error on the hi instance via a forced case-path fault.
    step("fault_set",    1'b1, 2'b10, 1'b0, 1'b1);
    step("err_persist",  1'b1, 2'b01, 1'b0, 1'b0);
    step("fault_masked", 1'b0, 2'b11, 1'b0, 1'b1);
    step("err_clear",    1'b1, 2'b00, 1'b1, 1'b0);
    step("fault_again",  1'b1, 2'b11, 1'b0, 1'b1);
    step("clr_in_fault", 1'b1, 2'b01, 1'b1, 1'b1);
    step("err_held",     1'b0, 2'b00, 1'b0, 1'b0);
    step("err_clear2",   1'b0, 2'b00, 1'b1, 1'b0);

    // Random stimulus.
    for (int i = 0; i < 60; i++) begin
      step("random", 1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'b0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dec_2to4.md
DEC_2TO4 -- requirements
Module: dec_2to4

Interface
REQ-001 Parameter: ACTIVE_LOW, default 0; when 1, the decoded outputs are inverted (the selected line is 0 and the others are 1).
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: rst_n  input  1  asynchronous active-low reset.
REQ-004 Port: en  input  1  decode enable, sampled on clk.
REQ-005 Port: in  input  2  select code.
REQ-006 Port: err_clr  input  1  clears the sticky error flag, sampled on clk.
REQ-007 Port: out_logic  output  4  registered result of the gate-level decode path.
REQ-008 Port: out_cond  output  4  registered result of the conditional (case/if) decode path.
REQ-009 Port: out_valid  output  1  high when out_logic and out_cond hold a decode of an enabled sample.
REQ-010 Port: match  output  1  registered equality of the two decode paths.
REQ-011 Port: err  output  1  sticky flag, set on any enabled-cycle mismatch between the paths.
REQ-012 Design: one clock domain; reset is asynchronous and active-low (rst_n), clock is clk.

Function
REQ-013 Logic path: built from AND/NOT terms only: bit0=~in1&~in0, bit1=~in1&in0, bit2=in1&~in0, bit3=in1&in0.
REQ-014 Conditional path: built from a case/conditional selection on in, with a default branch giving all-inactive.
REQ-015 Active-high decode (ACTIVE_LOW=0): both paths give 4'b0001 << in, i.e. 00->0001, 01->0010, 10->0100, 11->1000.
REQ-016 ACTIVE_LOW=1: each path output is the bitwise inverse of REQ-015.
REQ-017 Latency: on each rising clk edge with en=1, out_logic and out_cond load their path results for the current in, and out_valid goes to 1; 1-cycle latency.
REQ-018 Disabled cycle: on a rising edge with en=0, out_logic and out_cond load all-inactive (0000, or 1111 if ACTIVE_LOW=1), and out_valid goes to 0.
REQ-019 Match: updates every edge to (logic path result == conditional path result), using the same gating as REQ-017/018; in fault-free operation it is always 1.
REQ-020 Error set: err sets on an edge where en=1 and the path results differ.
REQ-021 Error clear: err clears on an edge where err_clr=1; set has priority over clear on the same edge.
REQ-022 Unknowns: X/Z on in drives out_cond to all-inactive via the default branch; no other X handling is required.
REQ-023 Registering: all outputs are registered, with no combinational path from inputs to outputs.
REQ-024 Encoding: while out_valid=1, exactly one bit of each output is active (one-hot, or one-cold when ACTIVE_LOW=1).

Reset
REQ-025 While rst_n=0, the following hold immediately, independent of clk: out_logic=out_cond=all-inactive (0000, or 1111 if ACTIVE_LOW=1), out_valid=0, match=1, err=0.
REQ-026 Reset release: first decode occurs on the first rising clk edge after rst_n rises.
REQ-027 Mid-operation reset: asserting rst_n mid-operation discards any in-flight decode, and outputs return to REQ-025 values asynchronously.

Verification
REQ-028 Sweep (ACTIVE_LOW=0, en=1): in=0,1,2,3 on successive cycles -> one cycle later out_logic=out_cond=0001,0010,0100,1000; match=1; out_valid=1; err=0.
REQ-029 Disable: en=0 with in=2 -> next edge outputs=0000, out_valid=0, match=1.
REQ-030 Active-low (ACTIVE_LOW=1, en=1): in=1 -> next edge outputs=1101; in=3 -> 0111.
REQ-031 Async reset: assert rst_n=0 between clock edges while outputs=1000 -> outputs=0000, out_valid=0 before the next edge; after release and in=0 -> 0001.
REQ-032 Sticky error: force a path mismatch for one enabled cycle -> err=1 and match=0; err persists after the mismatch is removed; err_clr=1 -> err=0 next edge; err_clr during a mismatch -> err stays 1.
REQ-033 One-hot check: for every valid cycle of a random stimulus, each output has exactly one active bit.
